spi_cmd_sequencer: RTL and testbench

SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

---
 rtl/spi_cmd_sequencer_pkg.sv | 15 +
 rtl/spi_cmd_sequencer_if.sv | 38 +++
 rtl/spi_cmd_sequencer_sync_fifo.sv | 49 ++++
 rtl/spi_cmd_sequencer.sv | 127 ++++++++++++
 tb/tb_spi_cmd_sequencer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared types and defaults for the SPI command sequencer.
package spi_seq_pkg;

    localparam int unsigned WordW            = 16;
    localparam int unsigned FifoDepthDefault = 4;
    localparam int unsigned TimeoutDefault   = 1023;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitDone,
        StStore
    } seq_state_e;

endpackage

// File: rtl/spi_cmd_sequencer_if.sv
// Command, response, SPI-master and status signals of the sequencer.
interface spi_cmd_sequencer_if;
    import spi_seq_pkg::*;

    logic [WordW-1:0] cmd_data;
    logic             cmd_valid;
    logic             cmd_ready;

    logic [WordW-1:0] rsp_data;
    logic             rsp_valid;
    logic             rsp_ready;

    logic [WordW-1:0] spi_data_transmit;
    logic             spi_start_transmit;
    logic             spi_transmit_complete;
    logic [WordW-1:0] spi_data_receive;

    logic             busy;
    logic             timeout_err;
    logic             err_clear;

    // Sequencer side.
    modport slave (
        input  cmd_data, cmd_valid, rsp_ready, spi_transmit_complete, spi_data_receive,
               err_clear,
        output cmd_ready, rsp_data, rsp_valid, spi_data_transmit, spi_start_transmit, busy,
               timeout_err
    );

    // Host / SPI-master side.
    modport master (
        output cmd_data, cmd_valid, rsp_ready, spi_transmit_complete, spi_data_receive,
               err_clear,
        input  cmd_ready, rsp_data, rsp_valid, spi_data_transmit, spi_start_transmit, busy,
               timeout_err
    );

endinterface

// File: rtl/spi_cmd_sequencer_sync_fifo.sv
// First-word-fall-through synchronous FIFO; pushes when full and pops when empty are ignored.
module sync_fifo
    import spi_seq_pkg::*;
#(
    parameter int unsigned DEPTH = FifoDepthDefault
) (
    input  logic             sysclk,
    input  logic             rst,
    input  logic             push,
    input  logic [WordW-1:0] push_data,
    input  logic             pop,
    output logic [WordW-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AddrW = $clog2(DEPTH);

    logic [WordW-1:0] mem_q [DEPTH];
    logic [AddrW:0]   wr_ptr_q;
    logic [AddrW:0]   rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit tells full from empty when the addresses match.
    assign full     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                      (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q[AddrW-1:0]];

    // Read/write pointer update.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty gates visibility.
    always_ff @(posedge sysclk) begin
        if (do_push) mem_q[wr_ptr_q[AddrW-1:0]] <= push_data;
    end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Feeds queued command words to an SPI master one at a time and queues the received words.
module spi_cmd_sequencer
    import spi_seq_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = FifoDepthDefault,
    parameter int unsigned TIMEOUT    = TimeoutDefault
) (
    input logic                sysclk,
    input logic                rst,
    spi_cmd_sequencer_if.slave bus
);

    localparam int unsigned    CntW   = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    seq_state_e       state_q, state_d;
    logic [WordW-1:0] tx_q, tx_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             err_q, err_set;
    logic             cmpl_meta_q, cmpl_s_q;
    logic             spi_start;

    logic             cmd_full, cmd_empty, cmd_pop;
    logic [WordW-1:0] cmd_head;
    logic             rsp_full, rsp_empty, rsp_push;

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .sysclk   (sysclk),
        .rst      (rst),
        .push     (bus.cmd_valid),
        .push_data(bus.cmd_data),
        .pop      (cmd_pop),
        .pop_data (cmd_head),
        .full     (cmd_full),
        .empty    (cmd_empty)
    );

    sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rsp_fifo (
        .sysclk   (sysclk),
        .rst      (rst),
        .push     (rsp_push),
        .push_data(bus.spi_data_receive),
        .pop      (bus.rsp_valid && bus.rsp_ready),
        .pop_data (bus.rsp_data),
        .full     (rsp_full),
        .empty    (rsp_empty)
    );

    // Complete synchronizer; resets high so reset alone never looks like a finished transfer.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            cmpl_meta_q <= 1'b1;
            cmpl_s_q    <= 1'b1;
        end else begin
            cmpl_meta_q <= bus.spi_transmit_complete;
            cmpl_s_q    <= cmpl_meta_q;
        end
    end

    // State, transmit word, timeout counter and sticky error.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_q <= StIdle;
            tx_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            cnt_q   <= cnt_d;
            err_q   <= err_set || (err_q && !bus.err_clear);
        end
    end

    // Next-state logic; a command is only launched once the SPI master reports idle.
    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        cnt_d     = cnt_q;
        cmd_pop   = 1'b0;
        rsp_push  = 1'b0;
        err_set   = 1'b0;
        spi_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!cmd_empty && !rsp_full && cmpl_s_q) begin
                    cmd_pop = 1'b1;
                    tx_d    = cmd_head;
                    cnt_d   = '0;
                    state_d = StStart;
                end
            end
            StStart: begin
                spi_start = 1'b1;
                if (cnt_q == CntMax) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (!cmpl_s_q) state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (cnt_q == CntMax) begin
                    err_set = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cmpl_s_q) state_d = StStore;
                end
            end
            StStore: begin
                rsp_push = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.cmd_ready          = !cmd_full;
    assign bus.rsp_valid          = !rsp_empty;
    assign bus.spi_data_transmit  = tx_q;
    assign bus.spi_start_transmit = spi_start;
    assign bus.busy               = (state_q != StIdle);
    assign bus.timeout_err        = err_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Randomized self-checking bench with a behavioural SPI master and a response scoreboard.
module tb_spi_cmd_sequencer;

    localparam int unsigned TIMEOUT = 1023;
    localparam int unsigned NRAND   = 24;

    logic sysclk;
    logic rst;

    spi_cmd_sequencer_if bus ();

    spi_cmd_sequencer #(
        .FIFO_DEPTH(4),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .sysclk(sysclk),
        .rst   (rst),
        .bus   (bus)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_starts = 0;
    bit          spi_hang = 1'b0;
    bit          spi_slow = 1'b0;
    logic [15:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // The SPI master model answers each word with its nibbles in reverse order.
    function automatic logic [15:0] nib_rev(input logic [15:0] w);
        return {w[3:0], w[7:4], w[11:8], w[15:12]};
    endfunction

    // SPI master: drops complete when started, raises it later with the answer.
    initial begin
        logic [15:0] word;
        bus.spi_transmit_complete = 1'b1;
        bus.spi_data_receive      = '0;
        forever begin
            @(negedge sysclk);
            if (bus.spi_start_transmit && bus.spi_transmit_complete && !spi_hang) begin
                word = bus.spi_data_transmit;
                bus.spi_transmit_complete = 1'b0;
                n_starts++;
                repeat (spi_slow ? 40 : $urandom_range(4, 8)) @(negedge sysclk);
                bus.spi_data_receive      = nib_rev(word);
                bus.spi_transmit_complete = 1'b1;
            end
        end
    end

    // Hold cmd_valid until the word is taken; record its expected answer.
    task automatic push_cmd(input logic [15:0] w);
        int unsigned t = 0;
        bus.cmd_data  = w;
        bus.cmd_valid = 1'b1;
        while (!bus.cmd_ready && t < 3000) begin
            @(negedge sysclk);
            t++;
        end
        if (bus.cmd_ready) exp_q.push_back(nib_rev(w));
        else check_eq("push_stall", bus.cmd_ready, 1);
        @(negedge sysclk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic pop_rsp(input string tag);
        int unsigned t = 0;
        logic [15:0] exp;
        while (!bus.rsp_valid && t < 3000) begin
            @(negedge sysclk);
            t++;
        end
        if (!bus.rsp_valid) begin
            check_eq({tag, "_wait"}, bus.rsp_valid, 1);
            return;
        end
        if (exp_q.size() == 0) begin
            check_eq({tag, "_extra"}, bus.rsp_data, 32'hFFFF_FFFF);
            return;
        end
        exp = exp_q.pop_front();
        check_eq(tag, bus.rsp_data, exp);
        bus.rsp_ready = 1'b1;
        @(negedge sysclk);
        bus.rsp_ready = 1'b0;
    endtask

    task automatic wait_busy(input logic level, input string tag);
        int unsigned t = 0;
        while (bus.busy !== level && t < 3000) begin
            @(negedge sysclk);
            t++;
        end
        if (bus.busy !== level) check_eq(tag, bus.busy, level);
    endtask

    // Counts busy cycles of an aborted transaction and checks the flag at its end.
    task automatic run_timeout(input logic [15:0] w, input string tag);
        int unsigned cnt = 0;
        push_cmd(w);
        wait_busy(1'b1, {tag, "_rise"});
        while (bus.busy && cnt < 3000) begin
            @(negedge sysclk);
            cnt++;
        end
        check_eq({tag, "_len"}, (cnt >= TIMEOUT) && (cnt <= TIMEOUT + 2), 1);
        check_eq({tag, "_err"}, bus.timeout_err, 1);
        check_eq({tag, "_norsp"}, bus.rsp_valid, 0);
        exp_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int unsigned s0;
        int unsigned bad;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        bus.err_clear = 1'b0;
        repeat (3) @(negedge sysclk);
        rst = 1'b0;
        @(negedge sysclk);

        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_start", bus.spi_start_transmit, 0);
        check_eq("rst_err", bus.timeout_err, 0);
        check_eq("rst_rsp_valid", bus.rsp_valid, 0);
        check_eq("rst_cmd_ready", bus.cmd_ready, 1);
        check_eq("rst_tx", bus.spi_data_transmit, 0);

        // Popping an empty response queue does nothing.
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge sysclk);
        check_eq("empty_pop", bus.rsp_valid, 0);
        bus.rsp_ready = 1'b0;

        // Single command.
        s0 = n_starts;
        push_cmd(16'hA5C3);
        wait_busy(1'b1, "single_busy_rise");
        wait_busy(1'b0, "single_busy_fall");
        check_eq("single_starts", n_starts - s0, 1);
        check_eq("single_data", bus.rsp_data, 16'h3C5A);
        pop_rsp("single_rsp");
        check_eq("single_only_one", bus.rsp_valid, 0);

        // Burst into a stalled response queue, then fill the command queue.
        s0 = n_starts;
        for (int i = 1; i <= 4; i++) push_cmd(16'(i));
        bad = 0;
        while (!((n_starts - s0 == 4) && !bus.busy) && bad < 5000) begin
            @(negedge sysclk);
            bad++;
        end
        check_eq("burst_starts", n_starts - s0, 4);
        check_eq("burst_rsp_valid", bus.rsp_valid, 1);
        check_eq("burst_cmd_ready", bus.cmd_ready, 1);
        push_cmd(16'h0005);
        s0 = n_starts;
        repeat (40) @(negedge sysclk);
        check_eq("burst_5th_held", n_starts - s0, 0);
        check_eq("burst_5th_idle", bus.busy, 0);
        for (int i = 6; i <= 8; i++) push_cmd(16'(i));
        check_eq("cmd_full_ready", bus.cmd_ready, 0);
        bus.cmd_data  = 16'h0009;
        bus.cmd_valid = 1'b1;
        repeat (2) @(negedge sysclk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 8; i++) pop_rsp("burst_rsp");
        repeat (30) @(negedge sysclk);
        check_eq("burst_no_extra", bus.rsp_valid, 0);
        check_eq("burst_idle", bus.busy, 0);

        // Timeout, sticky flag, recovery and clear.
        spi_hang = 1'b1;
        run_timeout(16'hBEEF, "to1");
        spi_hang = 1'b0;
        push_cmd(16'h1234);
        pop_rsp("to_recover_rsp");
        check_eq("to_sticky", bus.timeout_err, 1);
        bus.err_clear = 1'b1;
        @(negedge sysclk);
        bus.err_clear = 1'b0;
        check_eq("to_cleared", bus.timeout_err, 0);

        // Set and clear on the same cycle: set wins.
        spi_hang      = 1'b1;
        bus.err_clear = 1'b1;
        run_timeout(16'h5555, "to2");
        @(negedge sysclk);
        check_eq("to2_clear_after", bus.timeout_err, 0);
        bus.err_clear = 1'b0;
        spi_hang      = 1'b0;

        // Reset while the SPI master is still mid-transfer.
        spi_slow = 1'b1;
        push_cmd(16'hC0DE);
        bad = 0;
        while (bus.spi_transmit_complete && bad < 200) begin
            @(negedge sysclk);
            bad++;
        end
        repeat (6) @(negedge sysclk);
        check_eq("mid_busy", bus.busy, 1);
        check_eq("mid_start_low", bus.spi_start_transmit, 0);
        spi_slow = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge sysclk);
        rst = 1'b0;
        @(negedge sysclk);
        exp_q.delete();
        check_eq("mrst_busy", bus.busy, 0);
        check_eq("mrst_start", bus.spi_start_transmit, 0);
        check_eq("mrst_rsp_valid", bus.rsp_valid, 0);
        check_eq("mrst_cmd_ready", bus.cmd_ready, 1);
        check_eq("mrst_tx", bus.spi_data_transmit, 0);
        repeat (2) @(negedge sysclk);
        s0 = n_starts;
        push_cmd(16'h7E81);
        bad = 0;
        for (int t = 0; t < 200 && !bus.spi_transmit_complete; t++) begin
            if (bus.spi_start_transmit) bad++;
            @(negedge sysclk);
        end
        check_eq("mrst_no_early_start", bad, 0);
        pop_rsp("mrst_rsp");
        check_eq("mrst_starts", n_starts - s0, 1);

        // Randomized traffic with random back-pressure.
        fork
            begin
                for (int i = 0; i < NRAND; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge sysclk);
                    push_cmd(16'($urandom));
                end
            end
            begin
                int unsigned got = 0;
                int unsigned t   = 0;
                logic        rdy;
                logic [15:0] exp;
                while (got < NRAND && t < 20000) begin
                    rdy = ($urandom_range(0, 2) != 0);
                    bus.rsp_ready = rdy;
                    if (rdy && bus.rsp_valid) begin
                        if (exp_q.size() == 0) begin
                            check_eq("rand_extra", bus.rsp_data, 32'hFFFF_FFFF);
                        end else begin
                            exp = exp_q.pop_front();
                            check_eq("rand_rsp", bus.rsp_data, exp);
                        end
                        got++;
                    end
                    @(negedge sysclk);
                    t++;
                end
                bus.rsp_ready = 1'b0;
                check_eq("rand_count", got, NRAND);
            end
        join
        repeat (20) @(negedge sysclk);
        check_eq("end_rsp_valid", bus.rsp_valid, 0);
        check_eq("end_busy", bus.busy, 0);
        check_eq("end_err", bus.timeout_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
